uart_tx: RTL and testbench

- Standalone UART transmitter that serialises parallel words onto a single line using 8N1 framing, with 2 stop bits selectable by parameter.
- It is the sending end of the link that the echo path receives on.
- Used as the tx half inside the echo/ALU datapath, and as a stimulus driver toward the receiver in loopback benches.
- Bit timing matches the receiver: one bit lasts 8 oversample ticks, and one tick lasts `prescale` clock cycles.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, oversample rate and
// prescale width. The receiver uses the same constants so bit timing matches.
package uart_pkg;

  localparam int OversampleRate = 8;
  localparam int PrescaleWidth  = 16;
  localparam int TickCntWidth   = $clog2(OversampleRate);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // A prescale of zero would never produce a tick; run it as one cycle per tick.
  function automatic logic [PrescaleWidth-1:0] clamp_prescale(
    input logic [PrescaleWidth-1:0] p
  );
    return (p == '0) ? PrescaleWidth'(1) : p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: emits a one-cycle tick every prescale_i clocks.
// A start pulse restarts the count so the first tick of a frame lands exactly
// prescale_i cycles after the handshake.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [PrescaleWidth-1:0] prescale_i,
  output logic                     tick_o
);

  logic [PrescaleWidth-1:0] cnt_q, cnt_d;

  // Tick on the last cycle of each prescale period; restart on start or tick.
  always_comb begin
    tick_o = (cnt_q == (prescale_i - PrescaleWidth'(1)));
    cnt_d  = cnt_q + PrescaleWidth'(1);
    if (start_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing by default (StopBits selects 1 or 2 stop bits).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
// One bit lasts OversampleRate ticks; one tick lasts the latched prescale.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int StopBits  = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [PrescaleWidth-1:0] prescale_i,
  input  logic [DataWidth-1:0]     data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     tx_o,
  output logic                     busy_o
);

  localparam int BitCntWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  tx_state_e                state_q, state_d;
  logic [TickCntWidth-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BitCntWidth-1:0]   bit_cnt_q, bit_cnt_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic [DataWidth-1:0]     shreg_q, shreg_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic                     tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  logic                 tick;
  logic                 bit_end;
  logic                 start_pulse;
  logic [DataWidth-1:0] shift_nxt;

  uart_baud_gen u_baud_gen (
    .clk_i      (clk_i),
    .rst_ni     (reset_ni),
    .start_i    (start_pulse),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  assign bit_end   = tick && (tick_cnt_q == TickCntWidth'(OversampleRate - 1));
  assign shift_nxt = shreg_q >> 1;
  assign ready_o   = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign tx_o      = tx_q;

  // Next-state logic; tx_d follows the level of the state being entered so
  // the line changes on the same edge as the state register.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shreg_d     = shreg_q;
    prescale_d  = prescale_q;
    tx_d        = tx_q;
    start_pulse = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (state_q != IDLE && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + TickCntWidth'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (valid_i) begin
          state_d     = START;
          shreg_d     = data_i;
          prescale_d  = clamp_prescale(prescale_i);
          tick_cnt_d  = '0;
          bit_cnt_d   = '0;
          stop_cnt_d  = 1'b0;
          start_pulse = 1'b1;
          tx_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^data_i;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shift_nxt;
          if (bit_cnt_q == BitCntWidth'(DataWidth - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntWidth'(1);
            tx_d      = shift_nxt[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_cnt_q == 1'(StopBits - 1)) begin
            state_d    = IDLE;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, counters and the registered serial line; reset aborts any frame.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      prescale_q <= PrescaleWidth'(1);
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: one instance with one stop bit, one with two.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] prescale, prescale2;
  logic [7:0]  data, data2;
  logic        valid, valid2;
  logic        ready, tx, busy;
  logic        ready2, tx2, busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(.DataWidth(8), .StopBits(1)) dut (
    .clk_i(clk), .reset_ni(rst_n), .prescale_i(prescale), .data_i(data),
    .valid_i(valid), .ready_o(ready), .tx_o(tx), .busy_o(busy)
  );

  uart_tx #(.DataWidth(8), .StopBits(2)) dut2 (
    .clk_i(clk), .reset_ni(rst_n), .prescale_i(prescale2), .data_i(data2),
    .valid_i(valid2), .ready_o(ready2), .tx_o(tx2), .busy_o(busy2)
  );

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic int flen(input int stops);
    return 9 + PAR + stops;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; valid = 0; valid2 = 0; data = 0; data2 = 0;
    prescale = 16'd1; prescale2 = 16'd1;
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state tx=%b busy=%b ready=%b required 1/0/1", tx, busy, ready);
    end
    tests++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || ready2 !== 1'b1) begin
      fails++;
      $display("FAIL reset_state2 tx=%b busy=%b ready=%b required 1/0/1", tx2, busy2, ready2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
        fails++;
        $display("FAIL idle c=%0d tx=%b busy=%b ready=%b required 1/0/1", c, tx, busy, ready);
      end
    end
  endtask

  // 0xA5 at P=1 with data_i/prescale_i disturbed mid-frame.
  task automatic test_frame_p1();
    int tb = 8;
    int n = flen(1) * tb;
    @(negedge clk);
    data = 8'hA5; prescale = 16'd1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      tests++;
      if (tx !== exp_bit(8'hA5, c / tb) || ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL frame_a5 c=%0d tx=%b ready=%b busy=%b required tx=%b ready=0 busy=1",
                 c, tx, ready, busy, exp_bit(8'hA5, c / tb));
      end
      if (c == 20) begin
        data = 8'h00; prescale = 16'd7;
      end
      @(negedge clk);
    end
    tests++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_a5_end tx=%b ready=%b busy=%b required 1/1/0", tx, ready, busy);
    end
  endtask

  // 0x00 then 0xFF at P=3 with valid held high: one idle cycle between frames.
  task automatic test_back_to_back();
    int tb = 24;
    int fl = flen(1) * tb;
    logic exp_tx, exp_rdy;
    @(negedge clk);
    data = 8'h00; prescale = 16'd3; valid = 1'b1;
    @(negedge clk);
    data = 8'hFF;
    for (int c = 0; c <= 2 * fl + 1; c++) begin
      if (c < fl) begin
        exp_tx = exp_bit(8'h00, c / tb); exp_rdy = 1'b0;
      end else if (c == fl || c == 2 * fl + 1) begin
        exp_tx = 1'b1; exp_rdy = 1'b1;
      end else begin
        exp_tx = exp_bit(8'hFF, (c - fl - 1) / tb); exp_rdy = 1'b0;
      end
      tests++;
      if (tx !== exp_tx || ready !== exp_rdy) begin
        fails++;
        $display("FAIL back_to_back c=%0d tx=%b ready=%b required tx=%b ready=%b",
                 c, tx, ready, exp_tx, exp_rdy);
      end
      if (c == fl + 1) valid = 1'b0;
      @(negedge clk);
    end
  endtask

  // Abort 0x3C during data bit 3, then send 0x81 cleanly.
  task automatic test_reset_midframe();
    int tb = 8;
    int n = flen(1) * tb;
    @(negedge clk);
    data = 8'h3C; prescale = 16'd1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (34) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL async_abort tx=%b busy=%b ready=%b required 1/0/1", tx, busy, ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL post_abort_idle c=%0d tx=%b busy=%b required 1/0", c, tx, busy);
      end
    end
    data = 8'h81; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      tests++;
      if (tx !== exp_bit(8'h81, c / tb)) begin
        fails++;
        $display("FAIL frame_81 c=%0d tx=%b required %b", c, tx, exp_bit(8'h81, c / tb));
      end
      @(negedge clk);
    end
    tests++;
    if (ready !== 1'b1 || tx !== 1'b1) begin
      fails++;
      $display("FAIL frame_81_end tx=%b ready=%b required 1/1", tx, ready);
    end
  endtask

  // Two stop bits at P=2: stop level spans 32 cycles.
  task automatic test_stop2();
    int tb = 16;
    int n = flen(2) * tb;
    @(negedge clk);
    data2 = 8'h55; prescale2 = 16'd2; valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    for (int c = 0; c < n; c++) begin
      tests++;
      if (tx2 !== exp_bit(8'h55, c / tb) || ready2 !== 1'b0) begin
        fails++;
        $display("FAIL stop2 c=%0d tx=%b ready=%b required tx=%b ready=0",
                 c, tx2, ready2, exp_bit(8'h55, c / tb));
      end
      @(negedge clk);
    end
    tests++;
    if (ready2 !== 1'b1 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL stop2_end tx=%b ready=%b busy=%b required 1/1/0", tx2, ready2, busy2);
    end
  endtask

  // prescale_i = 0 must time exactly like prescale_i = 1.
  task automatic test_prescale0();
    int tb = 8;
    int n = flen(1) * tb;
    @(negedge clk);
    data = 8'h5A; prescale = 16'd0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      tests++;
      if (tx !== exp_bit(8'h5A, c / tb)) begin
        fails++;
        $display("FAIL prescale0 c=%0d tx=%b required %b", c, tx, exp_bit(8'h5A, c / tb));
      end
      @(negedge clk);
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL prescale0_end ready=%b required 1", ready);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  // 0x07 has odd weight, so the even-parity bit after bit 7 is 1.
  task automatic test_parity();
    @(negedge clk);
    data = 8'h07; prescale = 16'd1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9 * 8 + 3) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL parity_bit tx=%b busy=%b required 1/1", tx, busy);
    end
    repeat (20) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_frame_p1();
    test_back_to_back();
    test_reset_midframe();
    test_stop2();
    test_prescale0();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
